// File: rtl/wdg_pkg.sv
// -----------------------------------------------------------------------------
// wdg_pkg
//   Shared definitions for the watchdog controller: the kick key, the FSM
//   state encoding (also visible in CTRL[5:4]) and the register addresses.
//   No ports.
// -----------------------------------------------------------------------------
package wdg_pkg;

    localparam logic [31:0] KICK_KEY = 32'h0000_5A5A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_BITE = 2'd3
    } wdg_state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_KICK   = 2'd2;
    localparam logic [1:0] ADDR_WINDOW = 2'd3;

endpackage

// File: rtl/wdg_if.sv
// -----------------------------------------------------------------------------
// wdg_if
//   CPU register bus of the watchdog.
//   cfg_we     write strobe
//   cfg_addr   register select (CTRL, LOAD, KICK/COUNT, WINDOW)
//   cfg_wdata  write data
//   cfg_rdata  read data, driven combinationally by the slave from cfg_addr
// -----------------------------------------------------------------------------
interface wdg_if;

    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (output cfg_we, cfg_addr, cfg_wdata, input  cfg_rdata);
    modport slave  (input  cfg_we, cfg_addr, cfg_wdata, output cfg_rdata);

endinterface

// File: rtl/wdg_cnt.sv
// -----------------------------------------------------------------------------
// wdg_cnt
//   Watchdog down-counter. A load takes priority over a decrement; a
//   decrement at zero is dropped so the count never wraps below 0.
//   sys_clk     clock
//   res_n       synchronous active-low reset (count <- RST_VAL)
//   i_load      load i_load_val this cycle
//   i_load_val  value to load
//   i_dec       decrement by one (ignored at zero)
//   o_count     current count
//   o_zero      count is zero
// -----------------------------------------------------------------------------
module wdg_cnt #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             sys_clk,
    input  logic             res_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (!res_n) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !o_zero) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/wdg_ctrl.sv
// -----------------------------------------------------------------------------
// wdg_ctrl
//   Watchdog controller: register file (CTRL, LOAD, KICK/COUNT, WINDOW) and the
//   IDLE -> RUN -> WARN -> BITE sequencer driving the wdg_cnt down-counter.
//   All time is counted in mtick pulses. Only res_n leaves BITE.
//   sys_clk      clock
//   res_n        synchronous active-low reset
//   mtick        one-cycle tick from mtime
//   cfg          register bus (wdg_if.slave)
//   count_wdg    current down-count
//   wdg_irq      early warning, high in WARN
//   wdg_rst_req  reset request, high in BITE
//   Build option: define WDG_WINDOW_EN to enable the WINDOW register and the
//   early-kick check; otherwise WINDOW reads 0 and no window logic exists.
// -----------------------------------------------------------------------------
module wdg_ctrl
    import wdg_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int WARN_TICKS = 8
) (
    input  logic             sys_clk,
    input  logic             res_n,
    input  logic             mtick,
    wdg_if.slave             cfg,
    output logic [WIDTH-1:0] count_wdg,
    output logic             wdg_irq,
    output logic             wdg_rst_req
);

    localparam logic [WIDTH-1:0] WARN_RELOAD = WIDTH'(WARN_TICKS - 1);

    wdg_state_e       r_state;
    wdg_state_e       w_state_nxt;
    logic             r_en;
    logic             r_lock;
    logic [WIDTH-1:0] r_load;

    logic             w_cnt_load;
    logic [WIDTH-1:0] w_cnt_load_val;
    logic             w_cnt_dec;
    logic [WIDTH-1:0] w_count;
    logic             w_zero;

    logic             w_wr_live;
    logic             w_kick;
    logic             w_early;
    logic             w_bad_kick;
    logic             w_good_kick;

    wdg_cnt #(
        .WIDTH   (WIDTH),
        .RST_VAL ({WIDTH{1'b1}})
    ) u_cnt (
        .sys_clk    (sys_clk),
        .res_n      (res_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // BITE freezes the whole register file.
    assign w_wr_live   = cfg.cfg_we && (r_state != ST_BITE);
    assign w_kick      = cfg.cfg_we && (cfg.cfg_addr == ADDR_KICK) &&
                         ((r_state == ST_RUN) || (r_state == ST_WARN));

`ifdef WDG_WINDOW_EN
    logic [WIDTH-1:0] r_window;

    always_ff @(posedge sys_clk) begin
        if (!res_n) begin
            r_window <= '0;
        end else if (w_wr_live && (cfg.cfg_addr == ADDR_WINDOW) && !r_lock) begin
            r_window <= cfg.cfg_wdata[WIDTH-1:0];
        end
    end

    // Only RUN is windowed; WINDOW=0 means every kick is in-window.
    assign w_early = (r_state == ST_RUN) && (r_window != '0) && (w_count > r_window);
`else
    assign w_early = 1'b0;
`endif

    assign w_bad_kick  = w_kick && ((cfg.cfg_wdata != KICK_KEY) || w_early);
    assign w_good_kick = w_kick && !w_bad_kick;

    always_ff @(posedge sys_clk) begin
        if (!res_n) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_lock  <= 1'b0;
            r_load  <= {WIDTH{1'b1}};
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_live && (cfg.cfg_addr == ADDR_CTRL)) begin
                if (!r_lock)         r_en   <= cfg.cfg_wdata[0];
                if (cfg.cfg_wdata[1]) r_lock <= 1'b1;
            end
            if (w_wr_live && (cfg.cfg_addr == ADDR_LOAD) && !r_lock) begin
                r_load <= cfg.cfg_wdata[WIDTH-1:0];
            end
        end
    end

    // Priority inside RUN/WARN: bad kick > good kick > en=0 > mtick.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = r_load;
        w_cnt_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_load = 1'b1;
                if (r_en) w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_WARN: begin
                if (w_bad_kick) begin
                    w_state_nxt    = ST_BITE;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = '0;
                end else if (w_good_kick) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_load  = 1'b1;
                end else if (!r_en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_load  = 1'b1;
                end else if (mtick) begin
                    if (!w_zero) begin
                        w_cnt_dec = 1'b1;
                    end else if (r_state == ST_RUN) begin
                        w_state_nxt    = ST_WARN;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = WARN_RELOAD;
                    end else begin
                        w_state_nxt = ST_BITE;
                    end
                end
            end
            ST_BITE: begin
                w_cnt_load     = 1'b1;
                w_cnt_load_val = '0;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg.cfg_rdata = '0;
        case (cfg.cfg_addr)
            ADDR_CTRL: begin
                cfg.cfg_rdata[0]   = r_en;
                cfg.cfg_rdata[1]   = r_lock;
                cfg.cfg_rdata[5:4] = r_state;
            end
            ADDR_LOAD:   cfg.cfg_rdata[WIDTH-1:0] = r_load;
            ADDR_KICK:   cfg.cfg_rdata[WIDTH-1:0] = w_count;
`ifdef WDG_WINDOW_EN
            ADDR_WINDOW: cfg.cfg_rdata[WIDTH-1:0] = r_window;
`endif
            default:     cfg.cfg_rdata = '0;
        endcase
    end

    assign count_wdg   = w_count;
    assign wdg_irq     = (r_state == ST_WARN);
    assign wdg_rst_req = (r_state == ST_BITE);

endmodule

// File: tb/tb_wdg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wdg_ctrl
//   Self-checking bench for wdg_ctrl: directed scenarios checked against fixed
//   expected values, then a randomized run checked against a behavioural model
//   of the watchdog rules. Honours WDG_WINDOW_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_wdg_ctrl;
    import wdg_pkg::*;

    localparam int WIDTH      = 16;
    localparam int WARN_TICKS = 8;
    localparam int MAXV       = 65535;
`ifdef WDG_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic              sys_clk = 1'b0;
    logic              res_n   = 1'b0;
    logic              mtick   = 1'b0;
    logic [WIDTH-1:0]  count_wdg;
    logic              wdg_irq;
    logic              wdg_rst_req;

    wdg_if bus ();

    wdg_ctrl #(
        .WIDTH      (WIDTH),
        .WARN_TICKS (WARN_TICKS)
    ) dut (
        .sys_clk     (sys_clk),
        .res_n       (res_n),
        .mtick       (mtick),
        .cfg         (bus),
        .count_wdg   (count_wdg),
        .wdg_irq     (wdg_irq),
        .wdg_rst_req (wdg_rst_req)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: state 0 IDLE, 1 RUN, 2 WARN, 3 BITE.
    int m_state, m_count, m_load, m_window;
    bit m_en, m_lock;

    task automatic model_step(input bit rst, input bit we, input logic [1:0] addr,
                              input logic [31:0] wdata, input bit tick);
        int  nxt_state, nxt_count;
        bit  kick, old_lock;
        if (!rst) begin
            m_state = 0; m_en = 0; m_lock = 0;
            m_load = MAXV; m_count = MAXV; m_window = 0;
            return;
        end
        old_lock  = m_lock;
        nxt_state = m_state;
        nxt_count = m_count;
        kick = we && (addr == 2'd2) && (m_state == 1 || m_state == 2);
        if (m_state == 3) begin
            nxt_count = 0;
        end else if (kick) begin
            if (wdata != KICK_KEY ||
                (WIN && m_state == 1 && m_window != 0 && m_count > m_window)) begin
                nxt_state = 3; nxt_count = 0;
            end else begin
                nxt_state = 1; nxt_count = m_load;
            end
        end else if (m_state == 0) begin
            nxt_count = m_load;
            if (m_en) nxt_state = 1;
        end else if (!m_en) begin
            nxt_state = 0; nxt_count = m_load;
        end else if (tick) begin
            if (m_count > 0)       nxt_count = m_count - 1;
            else if (m_state == 1) begin nxt_state = 2; nxt_count = WARN_TICKS - 1; end
            else                   nxt_state = 3;
        end
        if (we && m_state != 3) begin
            case (addr)
                2'd0: begin
                    if (!old_lock) m_en = wdata[0];
                    if (wdata[1])  m_lock = 1;
                end
                2'd1: if (!old_lock) m_load = int'(wdata) & MAXV;
                2'd3: if (WIN && !old_lock) m_window = int'(wdata) & MAXV;
                default: ;
            endcase
        end
        m_state = nxt_state;
        m_count = nxt_count;
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: begin r[0] = m_en; r[1] = m_lock; r[5:4] = 2'(m_state); end
            2'd1: r = 32'(m_load);
            2'd2: r = 32'(m_count);
            2'd3: r = WIN ? 32'(m_window) : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One clock cycle: inputs change on the falling edge, outputs are sampled
    // 1 time unit after the rising edge.
    task automatic drive(input bit rst, input bit we, input logic [1:0] addr,
                         input logic [31:0] wdata, input bit tick);
        @(negedge sys_clk);
        res_n         = rst;
        bus.cfg_we    = we;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wdata;
        mtick         = tick;
        model_step(rst, we, addr, wdata, tick);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();                              drive(0, 0, ADDR_CTRL, 32'd0, 0); endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d); drive(1, 1, a, d, 0);        endtask
    task automatic idle(input logic [1:0] a);               drive(1, 0, a, 32'd0, 0);         endtask
    task automatic tick(input int n);
        repeat (n) drive(1, 0, ADDR_KICK, 32'd0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        idle(ADDR_CTRL);
        n_checks++; if (bus.cfg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00000000", bus.cfg_rdata); end
        n_checks++; if (count_wdg !== 16'hFFFF) begin n_fail++; $display("FAIL reset_count: got %h expected ffff", count_wdg); end
        n_checks++; if (wdg_irq !== 1'b0 || wdg_rst_req !== 1'b0) begin n_fail++; $display("FAIL reset_outs: got irq=%b rst=%b expected 0 0", wdg_irq, wdg_rst_req); end
        idle(ADDR_LOAD);
        n_checks++; if (bus.cfg_rdata !== 32'h0000_FFFF) begin n_fail++; $display("FAIL reset_load: got %h expected 0000ffff", bus.cfg_rdata); end
    endtask

    task automatic test_expiry();
        do_reset();
        wr(ADDR_LOAD, 32'd3);
        wr(ADDR_CTRL, 32'd1);
        idle(ADDR_CTRL);
        n_checks++; if (bus.cfg_rdata[5:4] !== 2'd1 || count_wdg !== 16'd3) begin n_fail++; $display("FAIL exp_run: got state=%0d count=%0d expected 1 3", bus.cfg_rdata[5:4], count_wdg); end
        tick(3);
        n_checks++; if (count_wdg !== 16'd0 || wdg_irq !== 1'b0) begin n_fail++; $display("FAIL exp_zero: got count=%0d irq=%b expected 0 0", count_wdg, wdg_irq); end
        tick(1);
        n_checks++; if (wdg_irq !== 1'b1 || count_wdg !== 16'd7) begin n_fail++; $display("FAIL exp_warn: got irq=%b count=%0d expected 1 7", wdg_irq, count_wdg); end
        tick(7);
        n_checks++; if (wdg_rst_req !== 1'b0 || count_wdg !== 16'd0) begin n_fail++; $display("FAIL exp_warn_end: got rst=%b count=%0d expected 0 0", wdg_rst_req, count_wdg); end
        tick(1);
        n_checks++; if (wdg_rst_req !== 1'b1 || wdg_irq !== 1'b0) begin n_fail++; $display("FAIL exp_bite: got rst=%b irq=%b expected 1 0", wdg_rst_req, wdg_irq); end
    endtask

    task automatic test_kick();
        do_reset();
        wr(ADDR_LOAD, 32'd5);
        wr(ADDR_CTRL, 32'd1);
        idle(ADDR_CTRL);
        tick(2);
        n_checks++; if (count_wdg !== 16'd3) begin n_fail++; $display("FAIL kick_pre: got %0d expected 3", count_wdg); end
        wr(ADDR_KICK, KICK_KEY);
        n_checks++; if (count_wdg !== 16'd5) begin n_fail++; $display("FAIL kick_reload: got %0d expected 5", count_wdg); end
        idle(ADDR_CTRL);
        n_checks++; if (bus.cfg_rdata[5:4] !== 2'd1) begin n_fail++; $display("FAIL kick_state: got %0d expected 1", bus.cfg_rdata[5:4]); end
        tick(6);
        n_checks++; if (wdg_irq !== 1'b1) begin n_fail++; $display("FAIL kick_warn: got irq=%b expected 1", wdg_irq); end
        wr(ADDR_KICK, KICK_KEY);
        n_checks++; if (wdg_irq !== 1'b0 || count_wdg !== 16'd5) begin n_fail++; $display("FAIL kick_warn_clr: got irq=%b count=%0d expected 0 5", wdg_irq, count_wdg); end
    endtask

    task automatic test_bad_kick();
        do_reset();
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_KICK, 32'h0000_1234);           // ignored in IDLE
        n_checks++; if (wdg_rst_req !== 1'b0) begin n_fail++; $display("FAIL bad_idle: got rst=%b expected 0", wdg_rst_req); end
        wr(ADDR_LOAD, 32'd5);
        wr(ADDR_CTRL, 32'd1);
        idle(ADDR_CTRL);
        wr(ADDR_KICK, 32'h0000_1234);
        n_checks++; if (wdg_rst_req !== 1'b1) begin n_fail++; $display("FAIL bad_bite: got rst=%b expected 1", wdg_rst_req); end
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_KICK, KICK_KEY);
        wr(ADDR_LOAD, 32'd2);
        idle(ADDR_CTRL);
        n_checks++; if (wdg_rst_req !== 1'b1 || bus.cfg_rdata !== 32'h0000_0031) begin n_fail++; $display("FAIL bad_hold: got rst=%b ctrl=%h expected 1 00000031", wdg_rst_req, bus.cfg_rdata); end
        do_reset();
        n_checks++; if (wdg_rst_req !== 1'b0 || wdg_irq !== 1'b0 || count_wdg !== 16'hFFFF) begin n_fail++; $display("FAIL bad_reset: got rst=%b irq=%b count=%h expected 0 0 ffff", wdg_rst_req, wdg_irq, count_wdg); end
    endtask

    task automatic test_lock();
        do_reset();
        wr(ADDR_LOAD, 32'd5);
        wr(ADDR_CTRL, 32'd3);
        idle(ADDR_CTRL);
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_LOAD, 32'd9);
        idle(ADDR_CTRL);
        n_checks++; if (bus.cfg_rdata !== 32'h0000_0013) begin n_fail++; $display("FAIL lock_ctrl: got %h expected 00000013", bus.cfg_rdata); end
        idle(ADDR_LOAD);
        n_checks++; if (bus.cfg_rdata !== 32'd5) begin n_fail++; $display("FAIL lock_load: got %0d expected 5", bus.cfg_rdata); end
        tick(5);
        n_checks++; if (count_wdg !== 16'd0) begin n_fail++; $display("FAIL lock_zero: got %0d expected 0", count_wdg); end
        drive(1, 1, ADDR_KICK, KICK_KEY, 1);
        n_checks++; if (wdg_irq !== 1'b0 || count_wdg !== 16'd5) begin n_fail++; $display("FAIL lock_kick_tick: got irq=%b count=%0d expected 0 5", wdg_irq, count_wdg); end
    endtask

    task automatic test_window();
        do_reset();
        wr(ADDR_WINDOW, 32'd4);
        wr(ADDR_LOAD, 32'd10);
        wr(ADDR_CTRL, 32'd1);
        idle(ADDR_WINDOW);
        n_checks++; if (bus.cfg_rdata !== (WIN ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL win_read: got %0d expected %0d", bus.cfg_rdata, WIN ? 4 : 0); end
        tick(3);
        wr(ADDR_KICK, KICK_KEY);
        n_checks++; if (wdg_rst_req !== WIN) begin n_fail++; $display("FAIL win_early: got rst=%b expected %b", wdg_rst_req, WIN); end
        if (WIN) begin
            do_reset();
            wr(ADDR_WINDOW, 32'd4);
            wr(ADDR_LOAD, 32'd10);
            wr(ADDR_CTRL, 32'd1);
            idle(ADDR_CTRL);
            tick(7);
            wr(ADDR_KICK, KICK_KEY);
            n_checks++; if (wdg_rst_req !== 1'b0 || count_wdg !== 16'd10) begin n_fail++; $display("FAIL win_ok: got rst=%b count=%0d expected 0 10", wdg_rst_req, count_wdg); end
        end
    endtask

    task automatic test_load_zero();
        do_reset();
        wr(ADDR_LOAD, 32'd0);
        wr(ADDR_CTRL, 32'd1);
        idle(ADDR_CTRL);
        tick(1);
        n_checks++; if (wdg_irq !== 1'b1 || count_wdg !== 16'd7) begin n_fail++; $display("FAIL lz_warn: got irq=%b count=%0d expected 1 7", wdg_irq, count_wdg); end
        wr(ADDR_CTRL, 32'd0);
        idle(ADDR_CTRL);
        n_checks++; if (bus.cfg_rdata[5:4] !== 2'd0 || count_wdg !== 16'd0 || wdg_irq !== 1'b0) begin n_fail++; $display("FAIL lz_idle: got state=%0d count=%0d irq=%b expected 0 0 0", bus.cfg_rdata[5:4], count_wdg, wdg_irq); end
    endtask

    task automatic test_random();
        logic [1:0]  addr;
        logic [31:0] wdata;
        bit          rst, we, tk;
        int          r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r    = $urandom_range(0, 99);
            rst  = !(r < 2 || (m_state == 3 && r < 15));
            we   = ($urandom_range(0, 3) == 0);
            addr = 2'($urandom_range(0, 3));
            tk   = ($urandom_range(0, 2) == 0);
            case (addr)
                2'd0:    wdata = {30'd0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0)};
                2'd1:    wdata = 32'($urandom_range(0, 12));
                2'd2:    wdata = ($urandom_range(0, 99) < 85) ? KICK_KEY : $urandom;
                default: wdata = 32'($urandom_range(0, 8));
            endcase
            drive(rst, we, addr, wdata, tk);
            n_checks++; if (count_wdg !== m_count[15:0]) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count_wdg, m_count); end
            n_checks++; if (wdg_irq !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_irq[%0d]: got %b expected %b", i, wdg_irq, m_state == 2); end
            n_checks++; if (wdg_rst_req !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_rst[%0d]: got %b expected %b", i, wdg_rst_req, m_state == 3); end
            n_checks++; if (bus.cfg_rdata !== model_rdata(addr)) begin n_fail++; $display("FAIL rnd_rdata[%0d]: addr=%0d got %h expected %h", i, addr, bus.cfg_rdata, model_rdata(addr)); end
        end
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = 32'd0;
        test_reset();
        test_expiry();
        test_kick();
        test_bad_kick();
        test_lock();
        test_window();
        test_load_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
